vedic_mul_4bit: RTL and testbench
=================================

// Module: vedic_mul_4bit
// PURPOSE
//  Unsigned 4x4 -> 8-bit multiplier built on the Vedic Urdhva-Tiryagbhyam
//  (vertical-and-crosswise) scheme, with one registered output stage.
//  - Leaf arithmetic block for datapaths that need a small, fixed-latency product.
//  - Product is formed combinationally from four 2x2 partial products.
//  - The product is captured on every clock edge; there is no handshake.
// PARAMETERS
//  None. Widths are fixed: operands 4 bits, product 8 bits.
// PORTS
//  clk   in   1  single clock; rising edge
//  rst   in   1  reset, asynchronous, active-high
//  a     in   4  multiplicand, unsigned
//  b     in   4  multiplier, unsigned
//  c     out  8  product a*b, unsigned, registered
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high.
//  - Reset: while rst=1, c=8'h00 immediately, independent of clk.
//    c stays 0 until the first rising clk edge after rst falls.
//  - Latency: 1 cycle. At each rising clk edge with rst=0, c <= a*b, using the
//    a/b values present just before the edge. No throughput limit: a new
//    operand pair is accepted every cycle.
//  - Arithmetic: exact unsigned product, no truncation. Range is 0..225 (8'hE1).
//  - Partial products (2x2, each 4 bits wide):
//      q0=a[1:0]*b[1:0], q1=a[3:2]*b[1:0], q2=a[1:0]*b[3:2], q3=a[3:2]*b[3:2]
//  - Combine:
//      p[1:0] = q0[1:0]
//      t1[3:0] = q1 + {2'b00,q0[3:2]}          (max 11, no overflow)
//      t2[4:0] = {1'b0,q2} + {1'b0,t1}          (max 20)
//      p[3:2] = t2[1:0]
//      p[7:4] = q3 + {1'b0,t2[4:2]}             (max 14, no overflow)
//      c_next = p
//  - Boundaries:
//    - a=0 or b=0 -> product 0.
//    - a=b=15 -> 225.
//    - Operands that change between edges have no effect; only the values
//      present at the edge are sampled.
//    - rst asserted mid-stream clears c at once. The in-flight product is
//      discarded, not delivered later.
//    - X/Z operands propagate; no masking logic.
//  - No clock enable. No combinational path from a/b to c.
// STRUCTURE
//  - Shared package: VEDIC_OPW=4, VEDIC_PW=8, VEDIC_PPW=4 (2x2 product width).
//  - Sub-module vedic_mul_2bit (a[1:0], b[1:0] -> p[3:0]), purely combinational:
//      p0=a0&b0
//      {p2,p1} = half-add(a1&b0, a0&b1)
//      {p3,p2} = half-add(a1&b1, carry)
//  - Top level holds:
//    - 4x vedic_mul_2bit instances
//    - the three adders above (plain half/full-adder chains or '+')
//    - the 8-bit output register with async reset
// TESTING
//  1. rst=1 with a=11, b=14 and clk toggling -> c=8'h00 throughout.
//     Release rst; one edge later c=154 (8'h9A).
//  2. Back-to-back, one pair per cycle:
//     10*12, 13*9, 13*15, 15*9, 5*13
//     -> c = 120, 117, 195, 135, 65, each exactly 1 cycle after its operands.
//  3. Corner and repeat values: 0*15=0, 15*0=0, 15*15=225, 1*1=1,
//     and 13*15 held for 2 cycles -> c stays 195.
//  4. Second sequence: 15*13=195, 9*11=99, 5*3=15, 7*13=91, 13*13=169.
//  5. Assert rst asynchronously between edges while c=169 -> c=0 immediately.
//     After release, the next edge gives the current a*b.
//  6. Exhaustive sweep of all 256 (a,b) pairs against a reference model a*b,
//     checked one cycle later. Zero mismatches required.

Source files
------------

// File: rtl/vedic_mul_4bit_pkg.sv
// ---------------------------------------------------------------------------
// vedic_mul_4bit_pkg
//  Shared widths for the 4x4 Vedic (Urdhva-Tiryagbhyam) multiplier slice.
//  Widths are fixed. The constants are named so that every file uses the
//  same figures.
//    VEDIC_OPW : operand width (4)
//    VEDIC_PW  : full product width (8)
//    VEDIC_PPW : width of one 2x2 partial product (4)
// ---------------------------------------------------------------------------
package vedic_mul_4bit_pkg;

   localparam int VEDIC_OPW = 4;
   localparam int VEDIC_PW  = 8;
   localparam int VEDIC_PPW = 4;

endpackage : vedic_mul_4bit_pkg

// File: rtl/vedic_mul_2bit.sv
// ---------------------------------------------------------------------------
// vedic_mul_2bit
//  Purely combinational unsigned 2x2 -> 4-bit multiplier, built from two
//  half adders (vertical-and-crosswise on 2-bit operands).
//  Ports:
//    a [1:0]  in   multiplicand
//    b [1:0]  in   multiplier
//    p [3:0]  out  product a*b (0..9)
// ---------------------------------------------------------------------------
module vedic_mul_2bit
   import vedic_mul_4bit_pkg::*;
(
   input  logic [1:0]           a,
   input  logic [1:0]           b,
   output logic [VEDIC_PPW-1:0] p
);

   logic cross_hi;   // a1 & b0
   logic cross_lo;   // a0 & b1
   logic carry_1;    // carry out of the crosswise half adder
   logic vert_hi;    // a1 & b1

   assign cross_hi = a[1] & b[0];
   assign cross_lo = a[0] & b[1];
   assign vert_hi  = a[1] & b[1];

   // Vertical term of the low bits.
   assign p[0]    = a[0] & b[0];

   // Crosswise terms are summed by a half adder. The carry moves up into the
   // high vertical term, and a second half adder resolves it.
   assign p[1]    = cross_hi ^ cross_lo;
   assign carry_1 = cross_hi & cross_lo;
   assign p[2]    = vert_hi ^ carry_1;
   assign p[3]    = vert_hi & carry_1;

endmodule : vedic_mul_2bit

// File: rtl/vedic_mul_4bit.sv
// ---------------------------------------------------------------------------
// vedic_mul_4bit
//  Unsigned 4x4 -> 8-bit multiplier. It forms four 2x2 partial products and
//  combines them with three small adders. The result is registered once.
//  Latency is one cycle, and a new operand pair is taken every cycle.
//  Handshake: none. There is no valid/ready. On every rising clk edge with
//  rst low, c is loaded with the product of the a/b values present just
//  before that edge.
//  Ports:
//    clk      in   rising-edge clock
//    rst      in   asynchronous, active-high reset (clears c at once)
//    a [3:0]  in   multiplicand, unsigned
//    b [3:0]  in   multiplier, unsigned
//    c [7:0]  out  registered product a*b (0..225)
// ---------------------------------------------------------------------------
module vedic_mul_4bit
   import vedic_mul_4bit_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [VEDIC_OPW-1:0] a,
   input  logic [VEDIC_OPW-1:0] b,
   output logic [VEDIC_PW-1:0]  c
);

   logic [VEDIC_PPW-1:0] q0;      // a[1:0] * b[1:0]
   logic [VEDIC_PPW-1:0] q1;      // a[3:2] * b[1:0]
   logic [VEDIC_PPW-1:0] q2;      // a[1:0] * b[3:2]
   logic [VEDIC_PPW-1:0] q3;      // a[3:2] * b[3:2]
   logic [3:0]           t1;      // q1 + q0 carry-over bits (max 11)
   logic [4:0]           t2;      // q2 + t1                (max 20)
   logic [3:0]           p_hi;    // q3 + t2 carry-over bits (max 14)
   logic [VEDIC_PW-1:0]  p_next;

   vedic_mul_2bit u_pp0 (.a(a[1:0]), .b(b[1:0]), .p(q0));
   vedic_mul_2bit u_pp1 (.a(a[3:2]), .b(b[1:0]), .p(q1));
   vedic_mul_2bit u_pp2 (.a(a[1:0]), .b(b[3:2]), .p(q2));
   vedic_mul_2bit u_pp3 (.a(a[3:2]), .b(b[3:2]), .p(q3));

   // q0 weight 1, q1/q2 weight 4, q3 weight 16. Each stage keeps its low two
   // bits as product bits and passes the rest up to the next stage. The sum
   // bounds show that none of the adders can overflow its stated width.
   assign t1     = q1 + {2'b00, q0[3:2]};
   assign t2     = {1'b0, q2} + {1'b0, t1};
   assign p_hi   = q3 + {1'b0, t2[4:2]};
   assign p_next = {p_hi, t2[1:0], q0[1:0]};

   // Output register. This is the only path from a/b to c.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c <= '0;
      end else begin
         c <= p_next;
      end
   end

endmodule : vedic_mul_4bit

// File: tb/tb_vedic_mul_4bit.sv
// ---------------------------------------------------------------------------
// tb_vedic_mul_4bit
//  Directed bench for vedic_mul_4bit. Operands are driven on the falling
//  edge. c is sampled on the falling edge that follows the capturing rising
//  edge, so a pair driven at negedge k shows up on c at negedge k+1.
// ---------------------------------------------------------------------------
module tb_vedic_mul_4bit;

   logic       clk;
   logic       rst;
   logic [3:0] a;
   logic [3:0] b;
   logic [7:0] c;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_q[$];

   // Hand-computed stimulus tables.
   logic [3:0] s2_a [5] = '{4'd10, 4'd13, 4'd13, 4'd15, 4'd5};
   logic [3:0] s2_b [5] = '{4'd12, 4'd9,  4'd15, 4'd9,  4'd13};
   logic [7:0] s2_e [5] = '{8'd120, 8'd117, 8'd195, 8'd135, 8'd65};

   logic [3:0] s3_a [6] = '{4'd0,  4'd15, 4'd15, 4'd1, 4'd13, 4'd13};
   logic [3:0] s3_b [6] = '{4'd15, 4'd0,  4'd15, 4'd1, 4'd15, 4'd15};
   logic [7:0] s3_e [6] = '{8'd0, 8'd0, 8'd225, 8'd1, 8'd195, 8'd195};

   logic [3:0] s4_a [5] = '{4'd15, 4'd9,  4'd5, 4'd7,  4'd13};
   logic [3:0] s4_b [5] = '{4'd13, 4'd11, 4'd3, 4'd13, 4'd13};
   logic [7:0] s4_e [5] = '{8'd195, 8'd99, 8'd15, 8'd91, 8'd169};

   vedic_mul_4bit dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .b   (b),
      .c   (c)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      a   = 4'd11;
      b   = 4'd14;
      #1 rst = 1'b1;
      #1;
      total++;
      if (c !== 8'h00) begin
         bad++;
         $display("FAIL reset_async: c=%h expected=%h", c, 8'h00);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total++;
         if (c !== 8'h00) begin
            bad++;
            $display("FAIL reset_hold[%0d]: c=%h expected=%h", k, c, 8'h00);
         end
      end
      rst = 1'b0;
      #1;
      total++;
      if (c !== 8'h00) begin
         bad++;
         $display("FAIL reset_release_pre_edge: c=%h expected=%h", c, 8'h00);
      end
      @(negedge clk);
      total++;
      if (c !== 8'h9A) begin
         bad++;
         $display("FAIL reset_first_product: c=%h expected=%h", c, 8'h9A);
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k <= 5; k++) begin
         @(negedge clk);
         if (k > 0) begin
            total++;
            if (c !== s2_e[k-1]) begin
               bad++;
               $display("FAIL b2b[%0d]: c=%0d expected=%0d", k-1, c, s2_e[k-1]);
            end
         end
         if (k < 5) begin
            a = s2_a[k];
            b = s2_b[k];
         end
      end
   endtask

   task automatic test_corners();
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk);
         if (k > 0) begin
            total++;
            if (c !== s3_e[k-1]) begin
               bad++;
               $display("FAIL corner[%0d]: c=%0d expected=%0d", k-1, c, s3_e[k-1]);
            end
         end
         if (k < 6) begin
            a = s3_a[k];
            b = s3_b[k];
         end
      end
      // Operands change just after the capturing edge. c must keep the
      // product sampled at that edge.
      a = 4'd2;
      b = 4'd2;
      @(posedge clk);
      #1;
      a = 4'd15;
      b = 4'd15;
      @(negedge clk);
      total++;
      if (c !== 8'd4) begin
         bad++;
         $display("FAIL sample_at_edge: c=%0d expected=%0d", c, 8'd4);
      end
   endtask

   task automatic test_second_seq();
      for (int k = 0; k <= 5; k++) begin
         @(negedge clk);
         if (k > 0) begin
            total++;
            if (c !== s4_e[k-1]) begin
               bad++;
               $display("FAIL seq2[%0d]: c=%0d expected=%0d", k-1, c, s4_e[k-1]);
            end
         end
         if (k < 5) begin
            a = s4_a[k];
            b = s4_b[k];
         end
      end
   endtask

   task automatic test_async_reset();
      // a=b=13 is still applied, so c stays at 169.
      @(negedge clk);
      total++;
      if (c !== 8'd169) begin
         bad++;
         $display("FAIL async_pre: c=%0d expected=%0d", c, 8'd169);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (c !== 8'h00) begin
         bad++;
         $display("FAIL async_clear: c=%0d expected=%0d", c, 8'd0);
      end
      @(negedge clk);
      total++;
      if (c !== 8'h00) begin
         bad++;
         $display("FAIL async_held: c=%0d expected=%0d", c, 8'd0);
      end
      a   = 4'd6;
      b   = 4'd7;
      rst = 1'b0;
      #1;
      total++;
      if (c !== 8'h00) begin
         bad++;
         $display("FAIL async_release_pre_edge: c=%0d expected=%0d", c, 8'd0);
      end
      @(negedge clk);
      total++;
      if (c !== 8'd42) begin
         bad++;
         $display("FAIL async_after_release: c=%0d expected=%0d", c, 8'd42);
      end
   endtask

   task automatic test_exhaustive();
      logic [7:0] exp_v;
      int         errs;
      errs = 0;
      exp_q.delete();
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
               exp_v = exp_q.pop_front();
               total++;
               if (c !== exp_v) begin
                  bad++;
                  errs++;
                  if (errs <= 10)
                     $display("FAIL sweep: a=%0d b=%0d c=%0d expected=%0d",
                              a, b, c, exp_v);
               end
            end
            a = i[3:0];
            b = j[3:0];
            exp_q.push_back(8'(i * j));
         end
      end
      @(negedge clk);
      exp_v = exp_q.pop_front();
      total++;
      if (c !== exp_v) begin
         bad++;
         $display("FAIL sweep_last: c=%0d expected=%0d", c, exp_v);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_back_to_back();
      test_corners();
      test_second_seq();
      test_async_reset();
      test_exhaustive();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_vedic_mul_4bit
